demultiplexfb: RTL and testbench
================================

# demultiplexfb

- 16-way write distributor: one WIDTH-bit write stream is steered into sixteen registered output slots `d0`..`d15`.
- Each slot has a one-cycle update strobe; a write acknowledge is returned per accepted word.
- Supports an optional auto-increment pointer and a sequenced 16-cycle bank clear.
- It is the write-side counterpart to the team's 16:1 read mux `multiplexfb`: slots written here feed that mux's inputs.

## Interface
Parameters:
- `WIDTH`, 16, data width of `din` and of every slot.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `din`  in  WIDTH  write data.
- `sel`  in  4  target slot index, used when `auto`=0.
- `wr`  in  1  write request.
- `auto`  in  1  1 = target is the internal pointer, `sel` ignored (macro-gated).
- `clr`  in  1  request a sequenced clear of all slots.
- `ready`  out  1  1 = block can accept `wr`/`clr` this cycle.
- `ack`  out  1  one-cycle pulse, the cycle after a write is accepted.
- `strb`  out  16  one-hot pulse; bit k is high the cycle after slot k is written.
- `ptr`  out  4  current auto-increment pointer.
- `wrap`  out  1  one-cycle pulse when an auto write targets slot 15.
- `clr_done`  out  1  one-cycle pulse when the clear sequence completes.
- `d0`..`d15`  out  WIDTH each  slot registers.

## Operation
- FSM has two states.
  - IDLE: `ready`=1.
  - CLEAR: `ready`=0.
  - `ready` is decoded combinationally from the state.
- IDLE, `clr`=1: go to CLEAR and load the clear counter with 0. `clr` has priority over `wr`.
  - A simultaneous `wr` is discarded: no `ack`, no `strb`, no slot or pointer change.
- IDLE, `wr`=1, `clr`=0: write accepted.
  - Target slot t = `ptr` if `auto`=1, else `sel`.
  - Slot t is loaded with `din`.
- Auto write:
  - `ptr` is incremented modulo 16 (15 wraps to 0).
  - `wrap` pulses if t = 15.
- Non-auto write leaves `ptr` unchanged.
- CLEAR: one slot is zeroed per cycle, counter 0→15.
  - After slot 15 is zeroed, return to IDLE, `ptr` is set to 0, and `clr_done` pulses.
  - Clearing does not assert `strb` or `ack`.
  - `wr` and `clr` are ignored while in CLEAR.
- A slot not being written holds its value.
- Writing the same slot on consecutive cycles is legal: the last write wins, and `strb` pulses on each.
- Reset (`rst_n`=0 at an edge):
  - Registered outputs become 0: all slots, `ptr`, `strb`, `ack`, `wrap`, `clr_done`.
  - FSM goes to IDLE, so `ready`=1.
  - Reset during CLEAR aborts the sequence. All slots are already zero from reset, and `clr_done` does not pulse.

## Timing
- Write latency: the write is accepted at edge N. From edge N onward:
  - the slot holds the new value;
  - `ack`, `strb[t]` and `wrap` are high for the cycle after edge N;
  - `ptr` shows the incremented value.
- Throughput: one write per cycle in IDLE.
- Clear: `clr` is accepted at edge N.
  - `ready` falls after edge N.
  - Slot k reads zero after edge N+1+k.
  - At edge N+16, slot 15 is zeroed, the FSM returns to IDLE, and `clr_done` and `ready` go high for the following cycle.
  - The first new write can be accepted at edge N+17.
- Back-to-back `clr` immediately after `clr_done` starts a new 16-cycle sequence.
- Pulse outputs are registered and never stretch beyond one cycle unless re-triggered.

## Configuration
- `DEMUXFB_AUTOINC_EN` defined:
  - `auto` is functional.
  - The `ptr` register and `wrap` generation exist as described.
- `DEMUXFB_AUTOINC_EN` undefined:
  - `auto` is ignored and the target is always `sel`.
  - `ptr` is tied to 0 and `wrap` to 0.
  - The clear sequence and everything else are unchanged.

## Test plan
- Reset, then write `din`=0xA5A5 with `sel`=7 → `d7`=0xA5A5 after the edge. Next cycle `ack`=1, `strb`=0x0080; all other slots stay 0.
- 17 auto writes with data 0x0100+i, starting from `ptr`=0:
  - `d0`..`d15` = 0x0100..0x010F, after which `d0` is overwritten with 0x0110.
  - `wrap` pulses once, after the 16th write.
  - `ptr`=1 at the end.
- Fill all slots with 0xFFFF, then pulse `clr`:
  - `ready` is low for 16 cycles and `d(k)`=0 after edge N+1+k.
  - `clr_done` pulses once, `ptr`=0, and no `strb` pulses occur.
- `clr`=1 and `wr`=1 (`sel`=3, 0x1234) in the same IDLE cycle → `d3` is never written and there is no `ack`; `wr` during CLEAR is also ignored.
- Assert `rst_n`=0 at clear step 5 → the next cycle has `ready`=1, all slots 0, `ptr`=0 and no `clr_done`. A subsequent write with `sel`=2 succeeds.
- Build without `DEMUXFB_AUTOINC_EN`: `auto`=1 with `sel`=9 and data 0x0F0F → `d9`=0x0F0F, `ptr`=0, `wrap`=0.

Source files
------------

// File: rtl/demultiplexfb.sv
// demultiplexfb -- 16-way write distributor.
//
// A single WIDTH-bit write stream is steered into sixteen registered slots
// d0..d15. Each accepted write loads one slot, pulses that slot's strobe bit
// and pulses ack, all visible the cycle after the write edge. A clear request
// walks a counter through all sixteen slots, zeroing one per cycle, then
// pulses clr_done. Slots written here feed the inputs of multiplexfb.
//
// Optional feature macro: DEMUXFB_AUTOINC_EN
//   defined   -> 'auto' selects the internal pointer as write target, the
//                pointer increments modulo 16 and 'wrap' flags slot 15.
//   undefined -> 'auto' is ignored, ptr and wrap are tied to 0.
//
// Ports:
//   clk       single clock, rising edge
//   rst_n     synchronous active-low reset
//   din       write data
//   sel       target slot when not auto-addressing
//   wr        write request
//   auto      use internal pointer as target (macro-gated)
//   clr       start a sequenced 16-cycle clear
//   ready     high when wr/clr can be accepted (IDLE)
//   ack       one-cycle pulse after an accepted write
//   strb      one-hot pulse, bit k after slot k was written
//   ptr       current auto-increment pointer
//   wrap      one-cycle pulse after an auto write to slot 15
//   clr_done  one-cycle pulse after the clear sequence finishes
//   d0..d15   slot registers
module demultiplexfb #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic [3:0]       sel,
  input  logic             wr,
  input  logic             auto,
  input  logic             clr,
  output logic             ready,
  output logic             ack,
  output logic [15:0]      strb,
  output logic [3:0]       ptr,
  output logic             wrap,
  output logic             clr_done,
  output logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] d4,
  output logic [WIDTH-1:0] d5,
  output logic [WIDTH-1:0] d6,
  output logic [WIDTH-1:0] d7,
  output logic [WIDTH-1:0] d8,
  output logic [WIDTH-1:0] d9,
  output logic [WIDTH-1:0] d10,
  output logic [WIDTH-1:0] d11,
  output logic [WIDTH-1:0] d12,
  output logic [WIDTH-1:0] d13,
  output logic [WIDTH-1:0] d14,
  output logic [WIDTH-1:0] d15
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [WIDTH-1:0] slot_reg [16];
  logic             ack_reg, clr_done_reg;
  logic [15:0]      strb_reg;

  logic             wr_en;      // write accepted this cycle
  logic             clear_en;   // a clear step zeroes slot cnt_reg this cycle
  logic             clear_last; // final clear step (slot 15)
  logic [3:0]       tgt;
  logic [3:0]       ptr_reg;

`ifdef DEMUXFB_AUTOINC_EN
  logic wrap_reg;
  assign tgt = auto ? ptr_reg : sel;
`else
  // auto has no function in this build; named so lint treats it as intentional
  logic unused_auto;
  assign unused_auto = auto;
  assign tgt         = sel;
`endif

  // Next-state and accept decode; clr wins over wr in IDLE.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ready      = 1'b0;
    wr_en      = 1'b0;
    clear_en   = 1'b0;
    clear_last = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (clr) begin
          state_next = CLEAR;
          cnt_next   = 4'd0;
        end else if (wr) begin
          wr_en = 1'b1;
        end
      end
      CLEAR: begin
        clear_en = 1'b1;
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == 4'd15) begin
          clear_last = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      ack_reg      <= 1'b0;
      strb_reg     <= 16'd0;
      clr_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      ack_reg      <= wr_en;
      strb_reg     <= wr_en ? (16'd1 << tgt) : 16'd0;
      clr_done_reg <= clear_last;
    end
  end

`ifdef DEMUXFB_AUTOINC_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_reg  <= 4'd0;
      wrap_reg <= 1'b0;
    end else begin
      wrap_reg <= wr_en && auto && (ptr_reg == 4'd15);
      if (clear_last)
        ptr_reg <= 4'd0;
      else if (wr_en && auto)
        ptr_reg <= ptr_reg + 4'd1;  // natural 4-bit wrap 15 -> 0
    end
  end
  assign wrap = wrap_reg;
`else
  assign ptr_reg = 4'd0;
  assign wrap    = 1'b0;
`endif

  // One register per slot; the clear step and a write can never coincide
  // because writes are only accepted in IDLE.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_slot
      localparam logic [3:0] IDX = 4'(gi);
      always_ff @(posedge clk) begin
        if (!rst_n)
          slot_reg[gi] <= '0;
        else if (clear_en && (cnt_reg == IDX))
          slot_reg[gi] <= '0;
        else if (wr_en && (tgt == IDX))
          slot_reg[gi] <= din;
      end
    end
  endgenerate

  assign ack      = ack_reg;
  assign strb     = strb_reg;
  assign ptr      = ptr_reg;
  assign clr_done = clr_done_reg;

  assign d0  = slot_reg[0];
  assign d1  = slot_reg[1];
  assign d2  = slot_reg[2];
  assign d3  = slot_reg[3];
  assign d4  = slot_reg[4];
  assign d5  = slot_reg[5];
  assign d6  = slot_reg[6];
  assign d7  = slot_reg[7];
  assign d8  = slot_reg[8];
  assign d9  = slot_reg[9];
  assign d10 = slot_reg[10];
  assign d11 = slot_reg[11];
  assign d12 = slot_reg[12];
  assign d13 = slot_reg[13];
  assign d14 = slot_reg[14];
  assign d15 = slot_reg[15];

endmodule

// File: tb/tb_demultiplexfb.sv
// tb_demultiplexfb -- self-checking bench for demultiplexfb.
// Directed steps from the test plan followed by a random phase, every cycle
// compared against a reference model of slot contents, pointer and pulses.
// Honours DEMUXFB_AUTOINC_EN the same way as the design.
module tb_demultiplexfb;

`ifdef DEMUXFB_AUTOINC_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, wr, auto, clr;
  logic [15:0] din;
  logic [3:0]  sel;
  logic        ready, ack, wrap, clr_done;
  logic [15:0] strb;
  logic [3:0]  ptr;
  logic [15:0] d [16];

  always #5 clk = ~clk;

  demultiplexfb #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .wr(wr), .auto(auto),
    .clr(clr), .ready(ready), .ack(ack), .strb(strb), .ptr(ptr),
    .wrap(wrap), .clr_done(clr_done),
    .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]), .d4(d[4]), .d5(d[5]),
    .d6(d[6]), .d7(d[7]), .d8(d[8]), .d9(d[9]), .d10(d[10]), .d11(d[11]),
    .d12(d[12]), .d13(d[13]), .d14(d[14]), .d15(d[15])
  );

  // Reference model state
  logic [15:0] m_slot [16];
  int          m_ptr = 0;
  bit          m_clearing = 1'b0;
  int          m_clr_edge = 0;
  int          edge_cnt = 0;
  bit          e_ack, e_wrap, e_done;
  logic [15:0] e_strb;

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, edge_cnt);
    end
  endtask

  task automatic check_all();
    check("ready", 32'(ready), 32'(!m_clearing));
    check("ack", 32'(ack), 32'(e_ack));
    check("strb", 32'(strb), 32'(e_strb));
    check("ptr", 32'(ptr), 32'(m_ptr));
    check("wrap", 32'(wrap), 32'(e_wrap));
    check("clr_done", 32'(clr_done), 32'(e_done));
    for (int k = 0; k < 16; k++)
      check($sformatf("d%0d", k), 32'(d[k]), 32'(m_slot[k]));
  endtask

  // Apply inputs for one cycle, advance the model at the edge, compare 1ns later.
  task automatic step(input bit r, input bit w, input bit a, input bit c,
                      input logic [3:0] s, input logic [15:0] dd);
    int t;
    int k;
    rst_n = r; wr = w; auto = a; clr = c; sel = s; din = dd;
    @(posedge clk);
    edge_cnt++;
    e_ack = 0; e_wrap = 0; e_done = 0; e_strb = 16'd0;
    if (!r) begin
      for (int i = 0; i < 16; i++) m_slot[i] = 16'd0;
      m_ptr = 0;
      m_clearing = 0;
    end else if (m_clearing) begin
      // slot k is zeroed at edge (accept edge + 1 + k)
      k = edge_cnt - m_clr_edge - 1;
      m_slot[k] = 16'd0;
      if (k == 15) begin
        m_clearing = 0;
        m_ptr = 0;
        e_done = 1;
      end
    end else if (c) begin
      m_clearing = 1;
      m_clr_edge = edge_cnt;
    end else if (w) begin
      t = (AUTO_EN && a) ? m_ptr : int'(s);
      m_slot[t] = dd;
      e_ack = 1;
      e_strb = 16'd1 << t;
      if (AUTO_EN && a) begin
        e_wrap = (t == 15);
        m_ptr = (m_ptr + 1) % 16;
      end
    end
    #1;
    $display("edge %0d rst_n=%0b wr=%0b auto=%0b clr=%0b sel=%0d din=%h | ready=%0b ack=%0b strb=%h ptr=%0d wrap=%0b done=%0b",
             edge_cnt, r, w, a, c, s, dd, ready, ack, strb, ptr, wrap, clr_done);
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_slot[i] = 16'd0;

    // Reset
    step(0, 0, 0, 0, 4'd0, 16'd0);
    step(0, 0, 0, 0, 4'd0, 16'd0);
    step(1, 0, 0, 0, 4'd0, 16'd0);

    // Single addressed write, then an idle cycle to see pulses drop
    step(1, 1, 0, 0, 4'd7, 16'hA5A5);
    step(1, 0, 0, 0, 4'd0, 16'd0);

    // 17 auto writes: fills all slots then overwrites the first
    for (int i = 0; i < 17; i++)
      step(1, 1, 1, 0, 4'(i * 5), 16'(16'h0100 + i));
    step(1, 0, 0, 0, 4'd0, 16'd0);

    // Fill with 0xFFFF, clear, and try writing throughout the clear
    for (int i = 0; i < 16; i++)
      step(1, 1, 0, 0, 4'(i), 16'hFFFF);
    step(1, 0, 0, 1, 4'd0, 16'd0);
    for (int i = 0; i < 17; i++)
      step(1, 1, 0, (i % 3) == 0, 4'(i), 16'hBEEF);

    // Back-to-back clear right after clr_done, with a competing write
    step(1, 1, 0, 0, 4'd3, 16'h5555);
    step(1, 1, 0, 1, 4'd3, 16'h1234);
    for (int i = 0; i < 16; i++)
      step(1, 0, 0, 0, 4'd0, 16'd0);
    step(1, 0, 0, 1, 4'd0, 16'd0);
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, 0, 4'd0, 16'd0);

    // Reset in the middle of a clear, then a normal write
    for (int i = 0; i < 14; i++)
      step(1, 0, 0, 0, 4'd0, 16'd0);
    for (int i = 0; i < 4; i++)
      step(1, 1, 1, 0, 4'(i), 16'(16'h7700 + i));
    step(1, 0, 0, 1, 4'd0, 16'd0);
    for (int i = 0; i < 5; i++)
      step(1, 0, 0, 0, 4'd0, 16'd0);
    step(0, 0, 0, 0, 4'd0, 16'd0);
    step(1, 1, 0, 0, 4'd2, 16'h2222);

    // auto with sel=9: slot 9 when the pointer is off, pointer slot otherwise
    step(1, 1, 1, 0, 4'd9, 16'h0F0F);
    step(1, 0, 0, 0, 4'd0, 16'd0);

    // Random traffic
    for (int n = 0; n < 600; n++)
      step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
           1'($urandom), $urandom_range(0, 24) == 0,
           4'($urandom), 16'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
